// File: rtl/mavg_cbm_pkg.sv
// Shared types and bus constants for the moving-average CybusM writer.
// Holds the controller state encoding and fixed single-word write attributes.
package mavg_cbm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [2:0]  CBM_SIZE_WORD    = 3'b010;
  localparam logic [2:0]  CBM_BURST_SINGLE = 3'b000;
  localparam logic [10:0] CBM_LEN_SINGLE   = 11'd1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mavg_window.sv
// Sample window: N-deep tap shift register plus a running sum over the taps.
// One shift per shift_en; the sum is updated incrementally (add newest, drop oldest).
module mavg_window
  import mavg_cbm_pkg::*;
#(
  parameter int DW        = 8,
  parameter int TAPS_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    shift_en,
  input  logic [DW-1:0]           din,
  output logic [DW+TAPS_LOG2-1:0] sum
);

  localparam int N  = 1 << TAPS_LOG2;
  localparam int SW = DW + TAPS_LOG2;

  logic [DW-1:0] tap_q [N];
  logic [DW-1:0] tap_d [N];
  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_d;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      tap_d[i] = tap_q[i];
    end
    sum_d = sum_q;
    if (shift_en) begin
      tap_d[0] = din;
      for (int i = 1; i < N; i++) begin
        tap_d[i] = tap_q[i-1];
      end
      // Intermediate may wrap, but the final sum always fits SW bits.
      sum_d = sum_q + SW'(din) - SW'(tap_q[N-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < N; i++) begin
        tap_q[i] <= '0;
      end
      sum_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        tap_q[i] <= tap_d[i];
      end
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mavg_cbm_writer.sv
// Moving-average filter that writes each new average to the bus as a single
// word, stepping through a circular address region.
module mavg_cbm_writer
  import mavg_cbm_pkg::*;
#(
  parameter int          DW         = 8,
  parameter int          TAPS_LOG2  = 3,
  parameter logic [31:0] ADDR_BASE  = 32'h1000_FF00,
  parameter int          ADDR_WORDS = 16,
  parameter bit          ROUND_EN   = 1'b1
) (
  input  logic          bus1_HCLK,
  input  logic          bus1_HRESET,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] avg_out,
  output logic          avg_valid,
  output logic          ave8_MA_bus1_CBM_read_req,
  output logic          ave8_MA_bus1_CBM_write_req,
  output logic [2:0]    ave8_MA_bus1_CBM_burst,
  output logic [31:0]   ave8_MA_bus1_CBM_addr,
  output logic [10:0]   ave8_MA_bus1_CBM_length,
  output logic [2:0]    ave8_MA_bus1_CBM_size,
  output logic          ave8_MA_bus1_CBM_lock,
  output logic [31:0]   ave8_MA_bus1_CBM_write_data,
  input  logic [31:0]   ave8_MA_bus1_CBM_read_data,
  input  logic          ave8_MA_bus1_CBM_command_busy,
  input  logic          ave8_MA_bus1_CBM_data_ready,
  input  logic          ave8_MA_bus1_CBM_error,
  input  logic [10:0]   ave8_MA_bus1_CBM_count,
  output logic [7:0]    err_count
);

  localparam int SW    = DW + TAPS_LOG2;
  localparam int PTR_W = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam logic [SW:0]      RND      = ROUND_EN ? ((SW+1)'(1) << (TAPS_LOG2 - 1)) : '0;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ADDR_WORDS - 1);

  state_e           state_q, state_d;
  logic [DW-1:0]    avg_q, avg_d;
  logic             avg_valid_q, avg_valid_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       err_q, err_d;

  logic [SW-1:0] sum;
  logic [SW:0]   rounded;
  logic [SW:0]   shifted;
  logic [DW-1:0] avg_calc;
  logic          shift_en;
  logic          accept;
  logic          unused_inputs;

  assign unused_inputs = ^{ave8_MA_bus1_CBM_read_data, ave8_MA_bus1_CBM_count};

  assign shift_en = (state_q == ST_IDLE) && in_valid;
  assign accept   = !ave8_MA_bus1_CBM_command_busy && ave8_MA_bus1_CBM_data_ready;

  mavg_window #(
    .DW       (DW),
    .TAPS_LOG2(TAPS_LOG2)
  ) u_window (
    .clk     (bus1_HCLK),
    .srst    (bus1_HRESET),
    .shift_en(shift_en),
    .din     (in_data),
    .sum     (sum)
  );

  // One extra bit keeps the rounding add from wrapping before the shift.
  assign rounded  = {1'b0, sum} + RND;
  assign shifted  = rounded >> TAPS_LOG2;
  assign avg_calc = (|shifted[SW:DW]) ? '1 : shifted[DW-1:0];

  always_ff @(posedge bus1_HCLK) begin
    if (bus1_HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_CALC;
      ST_CALC:  state_d = ST_WRITE;
      ST_WRITE: if (ave8_MA_bus1_CBM_error || accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers; an errored write leaves the pointer in place.
  always_comb begin
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    ptr_d       = ptr_q;
    err_d       = err_q;
    if (state_q == ST_CALC) begin
      avg_d       = avg_calc;
      avg_valid_d = 1'b1;
    end
    if (state_q == ST_WRITE) begin
      if (ave8_MA_bus1_CBM_error) begin
        err_d = sat_inc8(err_q);
      end else if (accept) begin
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge bus1_HCLK) begin
    if (bus1_HRESET) begin
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      ptr_q       <= '0;
      err_q       <= '0;
    end else begin
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    in_ready                    = (state_q == ST_IDLE);
    ave8_MA_bus1_CBM_read_req   = 1'b0;
    ave8_MA_bus1_CBM_burst      = CBM_BURST_SINGLE;
    ave8_MA_bus1_CBM_lock       = 1'b0;
    ave8_MA_bus1_CBM_write_req  = 1'b0;
    ave8_MA_bus1_CBM_addr       = '0;
    ave8_MA_bus1_CBM_length     = '0;
    ave8_MA_bus1_CBM_size       = '0;
    ave8_MA_bus1_CBM_write_data = '0;
    if (state_q == ST_WRITE) begin
      ave8_MA_bus1_CBM_write_req  = 1'b1;
      ave8_MA_bus1_CBM_addr       = ADDR_BASE + (32'(ptr_q) << 2);
      ave8_MA_bus1_CBM_length     = CBM_LEN_SINGLE;
      ave8_MA_bus1_CBM_size       = CBM_SIZE_WORD;
      ave8_MA_bus1_CBM_write_data = 32'(avg_q);
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_mavg_cbm_writer.sv
// Directed bench: a rounding and a truncating instance share all inputs;
// expected averages and addresses are hand-computed per scenario.
module tb_mavg_cbm_writer;

  localparam int          DW    = 8;
  localparam int          TL    = 3;
  localparam logic [31:0] BASE  = 32'h1000_FF00;
  localparam int          WORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        busy = 1'b0;
  logic        data_ready = 1'b1;
  logic        bus_err = 1'b0;
  logic [31:0] read_data = '0;
  logic [10:0] count = '0;

  logic        in_ready_r, avg_valid_r, rreq_r, wreq_r, lock_r;
  logic [7:0]  avg_r, errc_r;
  logic [2:0]  burst_r, size_r;
  logic [31:0] addr_r, wdata_r;
  logic [10:0] len_r;

  logic        in_ready_t, avg_valid_t, rreq_t, wreq_t, lock_t;
  logic [7:0]  avg_t, errc_t;
  logic [2:0]  burst_t, size_t;
  logic [31:0] addr_t, wdata_t;
  logic [10:0] len_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mavg_cbm_writer #(.DW(DW), .TAPS_LOG2(TL), .ADDR_BASE(BASE), .ADDR_WORDS(WORDS), .ROUND_EN(1'b1)) dut (
    .bus1_HCLK(clk), .bus1_HRESET(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_r), .avg_out(avg_r), .avg_valid(avg_valid_r),
    .ave8_MA_bus1_CBM_read_req(rreq_r), .ave8_MA_bus1_CBM_write_req(wreq_r),
    .ave8_MA_bus1_CBM_burst(burst_r), .ave8_MA_bus1_CBM_addr(addr_r),
    .ave8_MA_bus1_CBM_length(len_r), .ave8_MA_bus1_CBM_size(size_r),
    .ave8_MA_bus1_CBM_lock(lock_r), .ave8_MA_bus1_CBM_write_data(wdata_r),
    .ave8_MA_bus1_CBM_read_data(read_data), .ave8_MA_bus1_CBM_command_busy(busy),
    .ave8_MA_bus1_CBM_data_ready(data_ready), .ave8_MA_bus1_CBM_error(bus_err),
    .ave8_MA_bus1_CBM_count(count), .err_count(errc_r)
  );

  mavg_cbm_writer #(.DW(DW), .TAPS_LOG2(TL), .ADDR_BASE(BASE), .ADDR_WORDS(WORDS), .ROUND_EN(1'b0)) dut_t (
    .bus1_HCLK(clk), .bus1_HRESET(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_t), .avg_out(avg_t), .avg_valid(avg_valid_t),
    .ave8_MA_bus1_CBM_read_req(rreq_t), .ave8_MA_bus1_CBM_write_req(wreq_t),
    .ave8_MA_bus1_CBM_burst(burst_t), .ave8_MA_bus1_CBM_addr(addr_t),
    .ave8_MA_bus1_CBM_length(len_t), .ave8_MA_bus1_CBM_size(size_t),
    .ave8_MA_bus1_CBM_lock(lock_t), .ave8_MA_bus1_CBM_write_data(wdata_t),
    .ave8_MA_bus1_CBM_read_data(read_data), .ave8_MA_bus1_CBM_command_busy(busy),
    .ave8_MA_bus1_CBM_data_ready(data_ready), .ave8_MA_bus1_CBM_error(bus_err),
    .ave8_MA_bus1_CBM_count(count), .err_count(errc_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample for one accepting edge; returns 1 ns into CALC.
  task automatic send_sample(input logic [7:0] d);
    int n = 0;
    while (in_ready_r !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (in_ready_r !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout in_ready=%b want=1", in_ready_r);
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({in_ready_r, avg_valid_r, wreq_r, rreq_r, lock_r} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=10000", {in_ready_r, avg_valid_r, wreq_r, rreq_r, lock_r});
    end
    total++;
    if ({addr_r, wdata_r, len_r, size_r, burst_r} !== '0) begin
      bad++;
      $display("FAIL reset_bus addr=%h data=%h len=%0d size=%0d burst=%0d want all 0", addr_r, wdata_r, len_r, size_r, burst_r);
    end
    total++;
    if ({avg_r, errc_r} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_regs avg=%h errc=%0d want 0/0", avg_r, errc_r);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    logic [7:0]  exp_avg;
    logic [31:0] exp_addr;
    for (int i = 0; i < 8; i++) begin
      send_sample(8'h10);
      total++;
      if ({wreq_r, avg_valid_r, in_ready_r} !== 3'b000) begin
        bad++;
        $display("FAIL ramp_calc_phase i=%0d got=%b want=000", i, {wreq_r, avg_valid_r, in_ready_r});
      end
      tick();
      exp_avg  = 8'(2 * (i + 1));
      exp_addr = BASE + 32'(4 * i);
      $display("write i=%0d addr=%h data=%h", i, addr_r, wdata_r);
      total++;
      if ({wreq_r, avg_valid_r, in_ready_r} !== 3'b110) begin
        bad++;
        $display("FAIL ramp_write_phase i=%0d got=%b want=110", i, {wreq_r, avg_valid_r, in_ready_r});
      end
      total++;
      if (avg_r !== exp_avg || avg_t !== exp_avg) begin
        bad++;
        $display("FAIL ramp_avg i=%0d got=%h/%h want=%h", i, avg_r, avg_t, exp_avg);
      end
      total++;
      if (wdata_r !== {24'h0, exp_avg} || addr_r !== exp_addr) begin
        bad++;
        $display("FAIL ramp_bus i=%0d data=%h addr=%h want %h/%h", i, wdata_r, addr_r, {24'h0, exp_avg}, exp_addr);
      end
      total++;
      if (len_r !== 11'd1 || size_r !== 3'b010 || burst_r !== 3'b000) begin
        bad++;
        $display("FAIL ramp_attr i=%0d len=%0d size=%b burst=%b want 1/010/000", i, len_r, size_r, burst_r);
      end
      tick();
      total++;
      if ({wreq_r, avg_valid_r, in_ready_r} !== 3'b001) begin
        bad++;
        $display("FAIL ramp_accept i=%0d got=%b want=001", i, {wreq_r, avg_valid_r, in_ready_r});
      end
    end
  endtask

  task automatic test_rounding();
    logic [7:0] samp  [3] = '{8'd12, 8'd3, 8'd1};
    logic [7:0] exp_r [3] = '{8'd2, 8'd2, 8'd2};
    logic [7:0] exp_t [3] = '{8'd1, 8'd1, 8'd2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_sample(samp[i]);
      tick();
      $display("write round i=%0d addr=%h data=%h/%h", i, addr_r, wdata_r, wdata_t);
      total++;
      if (avg_r !== exp_r[i] || avg_t !== exp_t[i]) begin
        bad++;
        $display("FAIL round_avg i=%0d got=%0d/%0d want=%0d/%0d", i, avg_r, avg_t, exp_r[i], exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    send_sample(8'd0);
    data_ready = 1'b0;
    tick();
    for (int c = 1; c <= 5; c++) begin
      $display("write stall cycle=%0d addr=%h data=%h req=%b", c, addr_r, wdata_r, wreq_r);
      total++;
      if (wreq_r !== 1'b1 || in_ready_r !== 1'b0 || addr_r !== BASE + 32'h0C || wdata_r !== 32'd2) begin
        bad++;
        $display("FAIL stall_hold c=%0d req=%b rdy=%b addr=%h data=%h want 1/0/%h/2", c, wreq_r, in_ready_r, addr_r, wdata_r, BASE + 32'h0C);
      end
      total++;
      if (avg_valid_r !== (c == 1)) begin
        bad++;
        $display("FAIL stall_avg_valid c=%0d got=%b want=%b", c, avg_valid_r, (c == 1));
      end
      if (c == 2) begin
        in_valid = 1'b1;
        in_data  = 8'hFF;
      end
      if (c == 4) begin
        data_ready = 1'b1;
        busy       = 1'b1;
      end
      if (c == 5) in_valid = 1'b0;
      tick();
    end
    total++;
    if (wreq_r !== 1'b1 || addr_r !== BASE + 32'h0C) begin
      bad++;
      $display("FAIL stall_cycle6 req=%b addr=%h want 1/%h", wreq_r, addr_r, BASE + 32'h0C);
    end
    busy = 1'b0;
    tick();
    total++;
    if (wreq_r !== 1'b0 || in_ready_r !== 1'b1) begin
      bad++;
      $display("FAIL stall_release req=%b rdy=%b want 0/1", wreq_r, in_ready_r);
    end
  endtask

  task automatic test_error();
    send_sample(8'd0);
    tick();
    bus_err = 1'b1;
    tick();
    bus_err = 1'b0;
    total++;
    if (errc_r !== 8'd1 || errc_t !== 8'd1 || wreq_r !== 1'b0 || in_ready_r !== 1'b1) begin
      bad++;
      $display("FAIL error_count errc=%0d/%0d req=%b rdy=%b want 1/1/0/1", errc_r, errc_t, wreq_r, in_ready_r);
    end
    send_sample(8'd0);
    tick();
    $display("write retry addr=%h data=%h", addr_r, wdata_r);
    total++;
    if (addr_r !== BASE + 32'h10 || avg_r !== 8'd2) begin
      bad++;
      $display("FAIL error_reuse_addr addr=%h avg=%0d want %h/2", addr_r, avg_r, BASE + 32'h10);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_sample(8'd0);
      tick();
      $display("write wrap i=%0d addr=%h", i, addr_r);
      total++;
      if (addr_r !== BASE + 32'(4 * (i % 16))) begin
        bad++;
        $display("FAIL wrap_addr i=%0d got=%h want=%h", i, addr_r, BASE + 32'(4 * (i % 16)));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_write();
    send_sample(8'h80);
    tick();
    total++;
    if (wreq_r !== 1'b1 || avg_r !== 8'd16 || addr_r !== BASE + 32'h4) begin
      bad++;
      $display("FAIL midrst_pre req=%b avg=%0d addr=%h want 1/16/%h", wreq_r, avg_r, addr_r, BASE + 32'h4);
    end
    rst = 1'b1;
    tick();
    total++;
    if (wreq_r !== 1'b0 || in_ready_r !== 1'b1 || addr_r !== 32'h0 || avg_r !== 8'h0) begin
      bad++;
      $display("FAIL midrst_drop req=%b rdy=%b addr=%h avg=%h want 0/1/0/0", wreq_r, in_ready_r, addr_r, avg_r);
    end
    rst = 1'b0;
    send_sample(8'd8);
    tick();
    $display("write after_reset addr=%h data=%h", addr_r, wdata_r);
    total++;
    if (avg_r !== 8'd1 || avg_t !== 8'd1 || addr_r !== BASE) begin
      bad++;
      $display("FAIL midrst_sum_cleared avg=%0d/%0d addr=%h want 1/1/%h", avg_r, avg_t, addr_r, BASE);
    end
    tick();
  endtask

  task automatic test_full_scale();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_sample(8'hFF);
      tick();
      tick();
    end
    total++;
    if (avg_r !== 8'hFF || avg_t !== 8'hFF) begin
      bad++;
      $display("FAIL full_scale avg=%h/%h want ff/ff", avg_r, avg_t);
    end
  endtask

  task automatic test_err_saturate();
    do_reset();
    bus_err = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_sample(8'd0);
      tick();
      tick();
    end
    bus_err = 1'b0;
    $display("error burst done errc=%0d", errc_r);
    total++;
    if (errc_r !== 8'd255 || errc_t !== 8'd255) begin
      bad++;
      $display("FAIL err_saturate errc=%0d/%0d want 255", errc_r, errc_t);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_rounding();
    test_stall();
    test_error();
    test_wrap();
    test_reset_mid_write();
    test_full_scale();
    test_err_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
